hd_program_loader: RTL and testbench

//   HD-side transmitter that streams one stored program from the HD word store into MEMInstrucoes.

---
 rtl/hd_program_loader.sv | 133 +++++++++++++
 tb/tb_hd_program_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hd_program_loader.sv
// Streams one length-prefixed program from the HD word store into the instruction memory,
// one save pulse per word, then flags end-of-read until the next accepted start.
module hd_program_loader #(
  parameter int HD_ADDR_W = 10,
  parameter int SLOT_SIZE = 64,
  parameter int MAX_WORDS = 200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciarLeitura,
  input  logic [3:0]           programa,
  output logic [HD_ADDR_W-1:0] hd_endereco,
  output logic                 hd_leitura,
  input  logic [31:0]          hd_dado,
  output logic [31:0]          entradaDeInstrucao,
  output logic [1:0]           controleSalvaInstrucao,
  output logic [1:0]           ControleFimDeLeitura,
  output logic                 ocupado,
  output logic                 erroTamanho,
  output logic [31:0]          palavrasEnviadas
);

  localparam int LEN_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, HDR_REQ, HDR_WAIT, RD_REQ, RD_WAIT, WRITE, FINISH
  } state_t;

  state_t               state_r;
  logic [HD_ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     idx_r;
  logic [HD_ADDR_W-1:0] start_base_s;
  logic [LEN_W-1:0]     idx_next_s;

  // Word k of a program lives right after its header; the sum wraps at the HD address width.
  function automatic logic [HD_ADDR_W-1:0] word_addr(input logic [HD_ADDR_W-1:0] base,
                                                     input logic [LEN_W-1:0] idx);
    word_addr = base + HD_ADDR_W'(idx) + HD_ADDR_W'(1);
  endfunction

  assign start_base_s = HD_ADDR_W'(programa) * HD_ADDR_W'(SLOT_SIZE);
  assign idx_next_s   = idx_r + LEN_W'(1);

  // Transfer sequencer; every output is registered together with the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r                <= IDLE;
      base_r                 <= '0;
      len_r                  <= '0;
      idx_r                  <= '0;
      hd_endereco            <= '0;
      hd_leitura             <= 1'b0;
      entradaDeInstrucao     <= 32'd0;
      controleSalvaInstrucao <= 2'b00;
      ControleFimDeLeitura   <= 2'b00;
      ocupado                <= 1'b0;
      erroTamanho            <= 1'b0;
      palavrasEnviadas       <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (iniciarLeitura) begin
            base_r               <= start_base_s;
            palavrasEnviadas     <= 32'd0;
            erroTamanho          <= 1'b0;
            ControleFimDeLeitura <= 2'b00;
            ocupado              <= 1'b1;
            hd_leitura           <= 1'b1;
            hd_endereco          <= start_base_s;
            state_r              <= HDR_REQ;
          end
        end
        HDR_REQ: begin
          hd_leitura <= 1'b0;
          state_r    <= HDR_WAIT;
        end
        HDR_WAIT: begin
          idx_r <= '0;
          if (hd_dado == 32'd0) begin
            ControleFimDeLeitura <= 2'b01;
            ocupado              <= 1'b0;
            state_r              <= FINISH;
          end else begin
            // Oversized headers are clamped to the instruction memory depth and flagged.
            if (hd_dado > 32'(MAX_WORDS)) begin
              len_r       <= LEN_W'(MAX_WORDS);
              erroTamanho <= 1'b1;
            end else begin
              len_r <= hd_dado[LEN_W-1:0];
            end
            hd_leitura  <= 1'b1;
            hd_endereco <= word_addr(base_r, '0);
            state_r     <= RD_REQ;
          end
        end
        RD_REQ: begin
          hd_leitura <= 1'b0;
          state_r    <= RD_WAIT;
        end
        RD_WAIT: begin
          entradaDeInstrucao     <= hd_dado;
          controleSalvaInstrucao <= 2'b01;
          palavrasEnviadas       <= palavrasEnviadas + 32'd1;
          state_r                <= WRITE;
        end
        WRITE: begin
          controleSalvaInstrucao <= 2'b00;
          idx_r                  <= idx_next_s;
          if (idx_next_s == len_r) begin
            ControleFimDeLeitura <= 2'b01;
            ocupado              <= 1'b0;
            state_r              <= FINISH;
          end else begin
            hd_leitura  <= 1'b1;
            hd_endereco <= word_addr(base_r, idx_next_s);
            state_r     <= RD_REQ;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          controleSalvaInstrucao <= 2'b00;
          hd_leitura             <= 1'b0;
          ocupado                <= 1'b0;
          state_r                <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd_program_loader.sv
// Directed bench for hd_program_loader: a registered HD model, a table of transfers checked
// cycle by cycle against the expected save/read/finish timeline, plus a mid-transfer reset.
module tb_hd_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciarLeitura = 1'b0;
  logic [3:0]  programa = 4'd0;
  logic [9:0]  hd_endereco;
  logic        hd_leitura;
  logic [31:0] hd_dado = 32'd0;
  logic [31:0] entradaDeInstrucao;
  logic [1:0]  controleSalvaInstrucao;
  logic [1:0]  ControleFimDeLeitura;
  logic        ocupado;
  logic        erroTamanho;
  logic [31:0] palavrasEnviadas;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  prog;
    logic [31:0] hdr;
    int          n;
    logic        err;
    bit          noise;
  } vec_t;
  vec_t vecs [7];

  hd_program_loader dut (
    .clock(clock), .reset(reset), .iniciarLeitura(iniciarLeitura), .programa(programa),
    .hd_endereco(hd_endereco), .hd_leitura(hd_leitura), .hd_dado(hd_dado),
    .entradaDeInstrucao(entradaDeInstrucao), .controleSalvaInstrucao(controleSalvaInstrucao),
    .ControleFimDeLeitura(ControleFimDeLeitura), .ocupado(ocupado),
    .erroTamanho(erroTamanho), .palavrasEnviadas(palavrasEnviadas)
  );

  always #5 clock = ~clock;

  // HD store: data appears the cycle after the read strobe.
  always @(posedge clock) if (hd_leitura) hd_dado <= mem[hd_endereco];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse start, then compare every cycle up to one past FINISH. Cycle 1 is the one after the
  // start-sampling edge. stop_rel>0 returns right after sampling that cycle.
  task automatic run_xfer(input logic [3:0] prog, input int n, input logic err,
                          input bit noise, input int stop_rel);
    int base, fin, k;
    int bad_save, bad_data, bad_rd, bad_addr, bad_fim, bad_ocu;
    logic [1:0] exp_save;
    logic exp_rd;
    logic [9:0] exp_addr;
    base = int'(prog) * 64;
    fin = (n == 0) ? 3 : 3 + 3 * n;
    bad_save = 0; bad_data = 0; bad_rd = 0; bad_addr = 0; bad_fim = 0; bad_ocu = 0;
    @(negedge clock);
    iniciarLeitura = 1'b1;
    programa = prog;
    @(posedge clock);
    for (int rel = 1; rel <= fin + 1; rel++) begin
      @(negedge clock);
      exp_save = (rel >= 5 && (rel - 5) % 3 == 0 && (rel - 5) / 3 < n) ? 2'b01 : 2'b00;
      if (controleSalvaInstrucao !== exp_save) bad_save++;
      if (exp_save == 2'b01) begin
        k = (rel - 5) / 3;
        if (entradaDeInstrucao !== mem[(base + 1 + k) % 1024]) bad_data++;
      end
      exp_rd = (rel == 1) || (rel >= 3 && (rel - 3) % 3 == 0 && (rel - 3) / 3 < n);
      exp_addr = (rel == 1) ? 10'(base) : 10'((base + 1 + (rel - 3) / 3) % 1024);
      if (hd_leitura !== exp_rd) bad_rd++;
      if (exp_rd && hd_endereco !== exp_addr) bad_addr++;
      if (ControleFimDeLeitura !== ((rel >= fin) ? 2'b01 : 2'b00)) bad_fim++;
      if (ocupado !== (rel < fin)) bad_ocu++;
      if (noise && (rel == 2 || rel == 6 || rel == 9 || rel == fin)) begin
        iniciarLeitura = 1'b1;
        programa = 4'd5;
      end else begin
        iniciarLeitura = 1'b0;
      end
      if (stop_rel > 0 && rel == stop_rel) break;
    end
    check("save_timing", bad_save, 0);
    check("save_data", bad_data, 0);
    check("hd_strobe", bad_rd, 0);
    check("hd_addr", bad_addr, 0);
    check("fim_timing", bad_fim, 0);
    check("ocupado_timing", bad_ocu, 0);
    if (stop_rel == 0) begin
      check("word_count", palavrasEnviadas, 32'(n));
      check("erro_flag", 32'(erroTamanho), 32'(err));
      @(negedge clock);
      check("idle_after_finish", {30'd0, ocupado, hd_leitura}, 32'd0);
      check("fim_held_in_idle", 32'(ControleFimDeLeitura), 32'd1);
      check("count_held", palavrasEnviadas, 32'(n));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[129] = 32'h0000_00A1;
    mem[130] = 32'h0000_00A2;
    mem[131] = 32'h0000_00A3;

    vecs[0] = '{prog: 4'd2,  hdr: 32'd3,   n: 3,   err: 1'b0, noise: 1'b0};
    vecs[1] = '{prog: 4'd0,  hdr: 32'd0,   n: 0,   err: 1'b0, noise: 1'b0};
    vecs[2] = '{prog: 4'd1,  hdr: 32'd250, n: 200, err: 1'b1, noise: 1'b0};
    vecs[3] = '{prog: 4'd2,  hdr: 32'd3,   n: 3,   err: 1'b0, noise: 1'b1};
    vecs[4] = '{prog: 4'd3,  hdr: 32'd200, n: 200, err: 1'b0, noise: 1'b0};
    vecs[5] = '{prog: 4'd15, hdr: 32'd70,  n: 70,  err: 1'b0, noise: 1'b0};
    vecs[6] = '{prog: 4'd4,  hdr: 32'd201, n: 200, err: 1'b1, noise: 1'b0};

    repeat (3) @(negedge clock);
    check("rst_save", 32'(controleSalvaInstrucao), 32'd0);
    check("rst_fim", 32'(ControleFimDeLeitura), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_release_flags", {27'd0, ocupado, hd_leitura, erroTamanho,
                                controleSalvaInstrucao}, 32'd0);
    check("rst_release_count", palavrasEnviadas, 32'd0);
    check("rst_release_fim", 32'(ControleFimDeLeitura), 32'd0);

    for (int v = 0; v < 7; v++) begin
      mem[int'(vecs[v].prog) * 64] = vecs[v].hdr;
      run_xfer(vecs[v].prog, vecs[v].n, vecs[v].err, vecs[v].noise, 0);
    end

    mem[128] = 32'd3;
    run_xfer(4'd2, 3, 1'b0, 1'b0, 8);
    check("second_write_seen", 32'(controleSalvaInstrucao), 32'd1);
    check("second_word", entradaDeInstrucao, 32'h0000_00A2);
    reset = 1'b0;
    #1;
    check("midrst_flags", {27'd0, ocupado, hd_leitura, erroTamanho,
                           controleSalvaInstrucao}, 32'd0);
    check("midrst_fim", 32'(ControleFimDeLeitura), 32'd0);
    check("midrst_data", entradaDeInstrucao, 32'd0);
    check("midrst_count", palavrasEnviadas, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_xfer(4'd2, 3, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
